cpu_clock_sequencer: RTL and testbench
======================================

# cpu_clock_sequencer

Synthesizable instruction-period sequencer for the EE3613 CPU. It is driven by the single fast datapath clock `clk`. It generates the program-counter advance strobe and one-hot phase enables internally, so no separate slow clock is needed. It replaces the free-running 5:1 pcClk/clk pair with a parametrised divider that supports run, halt-at-boundary and single-step modes, and counts retired instruction periods. It sits at the CPU top level, between the debug/control inputs and every PC and datapath enable.

## Interface
- `PC_DIV`, default 5: `clk` cycles per instruction period. Legal range is 2 and up.
- `PH_W`, default `$clog2(PC_DIV)`: width of the phase index.
- `CNT_W`, default 32: width of the instruction counter.

- `clk`, in, 1: the only clock. All state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `run`, in, 1: level input. Requests free-running execution.
- `step`, in, 1: single-cycle pulse. Requests exactly one instruction period.
- `halt_req`, in, 1: requests a stop at the next period boundary.
- `phase`, out, `PH_W`: current phase, 0 to `PC_DIV-1`.
- `phase_oh`, out, `PC_DIV`: one-hot decode of `phase`. All zero when halted.
- `pc_en`, out, 1: one-cycle PC advance strobe, high in the last phase of each period.
- `halted`, out, 1: high when the state is IDLE.
- `instr_count`, out, `CNT_W`: number of `pc_en` strobes issued.

## Operation
- Three states: IDLE, RUN, STEP.
- **IDLE:**
  - `phase` is held at 0.
  - If `run` is high and `halt_req` is low, go to RUN.
  - Otherwise, if `step` is high, go to STEP.
  - If `run` and `step` are high together, RUN wins and the step is discarded.
  - `halt_req` is ignored in IDLE.
- **RUN and STEP:**
  - `phase` increments each cycle and wraps from `PC_DIV-1` to 0.
  - `pc_en` = (state is not IDLE) AND (`phase` == `PC_DIV-1`). It is decoded from registers only, with no combinational path from any input.
- **Leaving RUN:**
  - A sticky `stop_pend` flag is set in any RUN cycle where `halt_req` is high or `run` is low.
  - On the `pc_en` cycle:
    - If `stop_pend` is set, or is being set in that same cycle, go to IDLE and clear `stop_pend`.
    - Otherwise stay in RUN with `phase` at 0.
  - A period is never truncated.
- **STEP:**
  - Always completes exactly one period, then returns to IDLE.
  - `step`, `run` and `halt_req` are ignored during STEP.
  - `run` must be seen high in IDLE afterwards to start free-running.
- **Counter:**
  - `instr_count` increments by 1 on every `pc_en` cycle.
  - It wraps modulo 2^`CNT_W` without saturating and is never otherwise cleared.
- **Reset:**
  - State IDLE, `phase` 0, `phase_oh` 0, `pc_en` 0, `halted` 1, `instr_count` 0, `stop_pend` 0.
  - Asserting reset mid-period abandons the period: no `pc_en` is issued and the count is not changed.
  - `rst` has priority over every other input.

## Timing
- **Start latency:** `run` sampled high at edge t gives phase 0 in cycle t+1. `pc_en` is high in cycle t+`PC_DIV`, one cycle long.
- **Steady state:** exactly one `pc_en` every `PC_DIV` cycles, with no gaps between periods.
- **Stop latency:** `halted` rises one cycle after the `pc_en` that ends the last period. A stop request is therefore honoured within at most `PC_DIV` cycles.
- **Outputs:**
  - `halted` and `phase_oh` are registered-state decodes, valid in the same cycle as `phase`.
  - `instr_count` shows the new value in the cycle after `pc_en`.
- **Restart:** the earliest restart after halting is the cycle after `halted` first reads 1.

## Structure
- Shared package `cpu_pkg`:
  - Sequencer state enum: IDLE=2'd0, RUN=2'd1, STEP=2'd2.
  - Default `PC_DIV` constant, shared with the CPU top.
- Sub-module `phase_counter`:
  - Mod-`PC_DIV` counter with enable and clear.
  - Outputs `phase`, `phase_oh` and the terminal-count flag.
  - The FSM, `stop_pend` and `instr_count` stay in the parent.

## Test plan
All scenarios use `PC_DIV`=5.
- **Reset then free run:** hold `rst` 3 cycles, then `run`=1 at edge 0 → `halted`=1 during reset; `pc_en` in cycles 5, 10, 15; `instr_count` reads 3 after cycle 15.
- **Halt mid-period:** pulse `halt_req` while `phase`=1 → the period finishes with `pc_en` at `phase` 4, `halted`=1 in the next cycle, `phase` holds 0, and there are no further strobes.
- **Single step:** pulse `step` in IDLE with `run`=0 → exactly one `pc_en` 5 cycles later, then IDLE; a second `step` pulse during STEP is ignored and the count rises by exactly 1.
- **Simultaneous `run` and `step` in IDLE:** enters RUN; `pc_en` is periodic with no extra step period.
- **Reset mid-period:** assert `rst` at `phase`=3 → no `pc_en`, `instr_count` returns to 0, `halted`=1 the next cycle.
- **Wrap:** set `CNT_W`=4 and run 17 periods → `instr_count` goes 15, 0, 1.

Source files
------------

// File: rtl/cpu_clock_sequencer_pkg.sv
// Shared CPU package: sequencer state encoding and the default number of
// datapath clocks per instruction period (also used by the CPU top).
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } seq_state_t;

  localparam int PC_DIV_DEFAULT = 5;

endpackage

// File: rtl/cpu_clock_sequencer_if.sv
// Control/status bundle between the debug/control logic (master) and the
// instruction-period sequencer (slave).
//   run, step, halt_req : control requests into the sequencer
//   phase, phase_oh     : current phase index and its one-hot decode
//   pc_en               : one-cycle PC advance strobe
//   halted              : sequencer is idle
//   instr_count         : number of pc_en strobes issued
interface cpu_clock_sequencer_if #(
  parameter int PC_DIV = cpu_pkg::PC_DIV_DEFAULT,
  parameter int PH_W   = $clog2(PC_DIV),
  parameter int CNT_W  = 32
);
  logic              run;
  logic              step;
  logic              halt_req;
  logic [PH_W-1:0]   phase;
  logic [PC_DIV-1:0] phase_oh;
  logic              pc_en;
  logic              halted;
  logic [CNT_W-1:0]  instr_count;

  modport master (
    output run, step, halt_req,
    input  phase, phase_oh, pc_en, halted, instr_count
  );

  modport slave (
    input  run, step, halt_req,
    output phase, phase_oh, pc_en, halted, instr_count
  );
endinterface

// File: rtl/cpu_clock_sequencer_phase_counter.sv
// Mod-PC_DIV phase counter with enable and clear.
//   clk, rst : clock and synchronous active-high reset
//   en       : advance the phase this cycle (wraps PC_DIV-1 -> 0)
//   clr      : force phase to 0 (wins over en)
//   phase    : registered phase index
//   phase_oh : one-hot decode of phase
//   tc       : phase is at its terminal value PC_DIV-1
module phase_counter #(
  parameter int PC_DIV = 5,
  parameter int PH_W   = $clog2(PC_DIV)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  output logic [PH_W-1:0]   phase,
  output logic [PC_DIV-1:0] phase_oh,
  output logic              tc
);

  assign tc = (phase == PH_W'(PC_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= tc ? '0 : phase + PH_W'(1);
    end
  end

  always_comb begin
    phase_oh = '0;
    for (int i = 0; i < PC_DIV; i++) begin
      phase_oh[i] = (phase == PH_W'(i));
    end
  end

endmodule

// File: rtl/cpu_clock_sequencer.sv
// Instruction-period sequencer: divides clk into PC_DIV-cycle periods, issues
// a one-cycle pc_en at the end of each period and supports run,
// halt-at-boundary and single-step modes. Counts retired periods.
//   clk, rst : single datapath clock, synchronous active-high reset
//   bus      : control requests in, phase/strobe/status/count out
module cpu_clock_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_DIV = PC_DIV_DEFAULT,
  parameter int PH_W   = $clog2(PC_DIV),
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  cpu_clock_sequencer_if.slave  bus
);

  seq_state_t        state;
  logic              stop_pend;
  logic [CNT_W-1:0]  instr_count;
  logic              active;
  logic              tc;
  logic              stop_now;
  logic [PH_W-1:0]   phase;
  logic [PC_DIV-1:0] phase_oh_raw;

  assign active = (state != IDLE);

  phase_counter #(
    .PC_DIV (PC_DIV),
    .PH_W   (PH_W)
  ) u_phase (
    .clk      (clk),
    .rst      (rst),
    .en       (active),
    .clr      (!active),
    .phase    (phase),
    .phase_oh (phase_oh_raw),
    .tc       (tc)
  );

  // A stop request in RUN is latched and honoured only at the period boundary.
  assign stop_now = bus.halt_req || !bus.run;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      stop_pend   <= 1'b0;
      instr_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          stop_pend <= 1'b0;
          // run has priority; a coincident step is dropped
          if (bus.run && !bus.halt_req) begin
            state <= RUN;
          end else if (bus.step) begin
            state <= STEP;
          end
        end
        RUN: begin
          if (tc) begin
            if (stop_pend || stop_now) begin
              state     <= IDLE;
              stop_pend <= 1'b0;
            end
          end else if (stop_now) begin
            stop_pend <= 1'b1;
          end
        end
        STEP: begin
          if (tc) begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          stop_pend <= 1'b0;
        end
      endcase
      if (active && tc) begin
        instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

  // Status outputs are decoded from registers only.
  assign bus.phase       = phase;
  assign bus.phase_oh    = active ? phase_oh_raw : '0;
  assign bus.pc_en       = active && tc;
  assign bus.halted      = !active;
  assign bus.instr_count = instr_count;

endmodule

// File: tb/tb_cpu_clock_sequencer.sv
// Directed bench for cpu_clock_sequencer (PC_DIV=5). Expected per-cycle
// outputs are queued as each step is driven and compared after the edge.
// A second instance with CNT_W=4 exercises counter wrap.
module tb_cpu_clock_sequencer;

  logic clk;
  logic rst;

  cpu_clock_sequencer_if #(.PC_DIV(5), .CNT_W(32)) bus1 ();
  cpu_clock_sequencer_if #(.PC_DIV(5), .CNT_W(4))  bus2 ();

  cpu_clock_sequencer #(.PC_DIV(5), .CNT_W(32)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  cpu_clock_sequencer #(.PC_DIV(5), .CNT_W(4)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        pc_en;
    logic        halted;
    logic [2:0]  phase;
    logic [4:0]  oh;
    logic [31:0] cnt;
  } exp1_t;

  typedef struct {
    string      tag;
    logic       pc_en;
    logic [3:0] cnt;
  } exp2_t;

  exp1_t q1[$];
  exp2_t q2[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected outputs of the main instance for the cycle after the next edge.
  task automatic push1(input string tag, input int ph, input bit act, input int cnt);
    exp1_t e;
    e.tag    = tag;
    e.halted = !act;
    e.phase  = 3'(ph);
    e.pc_en  = act && (ph == 4);
    e.oh     = act ? (5'd1 << ph) : 5'd0;
    e.cnt    = 32'(cnt);
    q1.push_back(e);
  endtask

  task automatic push2(input string tag, input bit pc_en, input int cnt);
    exp2_t e;
    e.tag   = tag;
    e.pc_en = pc_en;
    e.cnt   = 4'(cnt);
    q2.push_back(e);
  endtask

  task automatic tick();
    exp1_t e1;
    exp2_t e2;
    @(posedge clk);
    @(negedge clk);
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      chk({e1.tag, ".pc_en"},  32'(bus1.pc_en),       32'(e1.pc_en));
      chk({e1.tag, ".halted"}, 32'(bus1.halted),      32'(e1.halted));
      chk({e1.tag, ".phase"},  32'(bus1.phase),       32'(e1.phase));
      chk({e1.tag, ".oh"},     32'(bus1.phase_oh),    32'(e1.oh));
      chk({e1.tag, ".count"},  bus1.instr_count,      e1.cnt);
    end
    if (q2.size() > 0) begin
      e2 = q2.pop_front();
      chk({e2.tag, ".pc_en"},  32'(bus2.pc_en),       32'(e2.pc_en));
      chk({e2.tag, ".count"},  32'(bus2.instr_count), 32'(e2.cnt));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus1.run = 1'b0; bus1.step = 1'b0; bus1.halt_req = 1'b0;
    bus2.run = 1'b0; bus2.step = 1'b0; bus2.halt_req = 1'b0;

    // reset held three cycles
    for (int i = 0; i < 3; i++) begin
      push1("reset", 0, 0, 0);
      push2("reset2", 1'b0, 0);
      tick();
    end

    // free run: pc_en after edges 5, 10, 15; count 3 after edge 16
    rst = 1'b0;
    bus1.run = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      push1("run", (i - 1) % 5, 1, (i - 1) / 5);
      tick();
    end

    // halt_req pulsed while phase=1; run stays high so stop must be sticky
    bus1.halt_req = 1'b1;
    push1("halt", 2, 1, 3);
    tick();
    bus1.halt_req = 1'b0;
    push1("halt", 3, 1, 3);
    tick();
    push1("halt", 4, 1, 3);
    tick();
    bus1.run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push1("halted", 0, 0, 4);
      tick();
    end

    // single step, second step pulse during STEP ignored
    bus1.step = 1'b1;
    push1("step", 0, 1, 4);
    tick();
    bus1.step = 1'b0;
    push1("step", 1, 1, 4);
    tick();
    bus1.step = 1'b1;
    push1("step", 2, 1, 4);
    tick();
    bus1.step = 1'b0;
    push1("step", 3, 1, 4);
    tick();
    push1("step", 4, 1, 4);
    tick();
    for (int i = 0; i < 5; i++) begin
      push1("step_idle", 0, 0, 5);
      tick();
    end

    // run and step together: plain periodic run
    bus1.run  = 1'b1;
    bus1.step = 1'b1;
    for (int i = 0; i < 19; i++) begin
      push1("runstep", i % 5, 1, 5 + i / 5);
      tick();
      bus1.step = 1'b0;
    end

    // reset while phase=3 abandons the period
    rst = 1'b1;
    bus1.run = 1'b0;
    push1("rst_mid", 0, 0, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push1("rst_idle", 0, 0, 0);
      tick();
    end

    // 4-bit counter wraps 15 -> 0 -> 1 over 17 periods
    bus2.run = 1'b1;
    for (int i = 0; i < 90; i++) begin
      push2("wrap", (i % 5) == 4, (i / 5) % 16);
      push1("idle_wrap", 0, 0, 0);
      tick();
    end
    bus2.run = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
